// File: rtl/lu_pkg.sv
// Shared definitions for the pipelined logic unit: operation codes,
// parameter limits and the saturating result counter ceiling.
// Contents: lu_op_t, OP_COUNT_MAX, LU_*_STAGES/WIDTH limits, sat_inc().
package lu_pkg;

  // Bitwise operation selector carried on the op port.
  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOR   = 3'b011,
    OP_XNOR  = 3'b100,
    OP_ANDN  = 3'b101,  // A & ~B
    OP_PASSA = 3'b110,
    OP_NOTA  = 3'b111
  } lu_op_t;

  // Completed-result counter stops here instead of wrapping.
  localparam logic [15:0] OP_COUNT_MAX = 16'hFFFF;

  // Elaboration limits for the unit's parameters.
  localparam int LU_MIN_STAGES = 1;
  localparam int LU_MAX_STAGES = 4;
  localparam int LU_MIN_WIDTH  = 8;
  localparam int LU_MAX_WIDTH  = 128;

  // Saturating increment for the 16-bit result counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == OP_COUNT_MAX) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/lu_pipe_stage.sv
// One valid/ready pipeline register holding DW data bits.
// Latency: 1 cycle; loads when empty or when its contents leave this cycle.
// Backpressure: holds contents and valid while out_ready is low.
// Ports: clk, reset (async, active-high); in_valid/in_data from upstream;
//        out_ready from downstream; out_valid/out_data to downstream.
module lu_pipe_stage #(
  parameter int DW = 66
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic can_load;
  logic load;

  // Room exists if empty, or if the current occupant is leaving this cycle.
  assign can_load = !out_valid || out_ready;
  assign load     = in_valid && can_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_logic_unit.sv
// Bitwise logic unit with an elastic valid/ready pipeline of STAGES registers.
// Latency: STAGES cycles from acceptance to out_valid when out_ready is held.
// Backpressure: out_ready low stalls the pipe; in_ready drops only when every stage is full.
// Ports: clk, reset (async, active-high); in_valid/in_ready, op, A, B on the input side;
//        out_valid/out_ready, out, zero, negative on the output side; op_count (saturating).
module pipelined_logic_unit
  import lu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  lu_op_t           op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             negative,
  output logic [15:0]      op_count
);

  // Each stage carries {negative, zero, result}.
  localparam int DW = WIDTH + 2;

  if (STAGES < LU_MIN_STAGES || STAGES > LU_MAX_STAGES) begin : g_bad_stages
    $fatal(1, "pipelined_logic_unit: STAGES must be in 1..4");
  end

  if (WIDTH < LU_MIN_WIDTH || WIDTH > LU_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "pipelined_logic_unit: WIDTH must be in 8..128");
  end

  logic [WIDTH-1:0]  result;
  logic [DW-1:0]     head_dat;
  logic [STAGES-1:0] stage_vld;
  logic [STAGES-1:0] stage_rdy;
  logic [DW-1:0]     stage_dat [STAGES];

  // ---------------------------------------------------------------------------
  // Stage-1 compute: all bits in parallel, no carries.
  // ---------------------------------------------------------------------------
  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:   result = A & B;
      OP_OR:    result = A | B;
      OP_XOR:   result = A ^ B;
      OP_NOR:   result = ~(A | B);
      OP_XNOR:  result = ~(A ^ B);
      OP_ANDN:  result = A & ~B;
      OP_PASSA: result = A;
      OP_NOTA:  result = ~A;
      default:  result = '0;
    endcase
  end

  // Flags are taken from the exact value that gets registered and travel in
  // the same register, so they can never be out of step with out. Keeping
  // them registered (rather than decoding out) also lets reset force zero=0
  // while out reads 0.
  assign head_dat = {result[WIDTH-1], (result == '0), result};

  // ---------------------------------------------------------------------------
  // Ready chain. Stage k may load if it or any stage downstream of it has a
  // hole, or the output is being taken. Built from the valid bits directly so
  // there is no combinational path from one stage's ready into another's.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic room;
    room      = out_ready;
    stage_rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room         = room || !stage_vld[k];
      stage_rdy[k] = room;
    end
  end

  assign in_ready = stage_rdy[0];

  // ---------------------------------------------------------------------------
  // Pipeline registers.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          vin;
    logic [DW-1:0] din;
    logic          down_rdy;

    if (k == 0) begin : g_head
      assign vin = in_valid;
      assign din = head_dat;
    end else begin : g_body
      assign vin = stage_vld[k-1];
      assign din = stage_dat[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign down_rdy = out_ready;
    end else begin : g_mid
      assign down_rdy = stage_rdy[k+1];
    end

    lu_pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .in_valid (vin),
      .in_data  (din),
      .out_ready(down_rdy),
      .out_valid(stage_vld[k]),
      .out_data (stage_dat[k])
    );
  end

  assign out_valid = stage_vld[STAGES-1];
  assign out       = stage_dat[STAGES-1][WIDTH-1:0];
  assign zero      = stage_dat[STAGES-1][WIDTH];
  assign negative  = stage_dat[STAGES-1][WIDTH+1];

  // ---------------------------------------------------------------------------
  // Completed-result counter, sticks at its maximum.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= sat_inc(op_count);
    end
  end

endmodule

// File: tb/tb_pipelined_logic_unit.sv
module tb_pipelined_logic_unit;
  import lu_pkg::*;

  localparam int W = 64;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default parameters)
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  lu_op_t        op = OP_AND;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out;
  logic          zero;
  logic          negative;
  logic [15:0]   op_count;

  // Narrow, single-stage build
  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  lu_op_t        s_op = OP_AND;
  logic [7:0]    s_a = '0;
  logic [7:0]    s_b = '0;
  logic          s_out_valid;
  logic          s_out_ready = 1'b1;
  logic [7:0]    s_out;
  logic          s_zero;
  logic          s_negative;
  logic [15:0]   s_op_count;

  pipelined_logic_unit #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .negative(negative), .op_count(op_count)
  );

  pipelined_logic_unit #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .A(s_a), .B(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .out(s_out),
    .zero(s_zero), .negative(s_negative), .op_count(s_op_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_cnt = 0;
  int hs_cyc[$];

  typedef struct {
    logic [W-1:0] res;
    int           t;
  } item_t;
  item_t q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input lu_op_t o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    case (o)
      OP_AND:   return x & y;
      OP_OR:    return x | y;
      OP_XOR:   return x ^ y;
      OP_NOR:   return ~(x | y);
      OP_XNOR:  return ~(x ^ y);
      OP_ANDN:  return x & ~y;
      OP_PASSA: return x;
      default:  return ~x;
    endcase
  endfunction

  // Model: a FIFO of accepted results in flight. The head is visible once it
  // has been in the pipe STAGES cycles; the pipe has room while it holds
  // fewer than STAGES results or the head is leaving.
  always @(negedge clk) begin
    logic exp_ov;
    logic exp_ir;
    if (reset) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      exp_ov = (q.size() > 0) && (q[0].t + S <= cyc);
      exp_ir = (q.size() < S) || out_ready;
      chk("in_ready", 128'(in_ready), 128'(exp_ir));
      chk("out_valid", 128'(out_valid), 128'(exp_ov));
      chk("op_count", 128'(op_count), 128'(exp_cnt));
      if (exp_ov) begin
        chk("out", 128'(out), 128'(q[0].res));
        chk("zero", 128'(zero), 128'(q[0].res == '0));
        chk("negative", 128'(negative), 128'(q[0].res[W-1]));
        if (out_ready) begin
          void'(q.pop_front());
          hs_cyc.push_back(cyc);
          if (exp_cnt < 65535) exp_cnt++;
        end
      end
      if (in_valid && exp_ir) q.push_back('{res: model(op, a, b), t: cyc});
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input lu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok = 1'b0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", 128'(ok), 128'(1));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    s_in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out", 128'(out), 128'(0));
    chk("rst_zero", 128'(zero), 128'(0));
    chk("rst_negative", 128'(negative), 128'(0));
    chk("rst_op_count", 128'(op_count), 128'(0));
    chk("rst8_out_valid", 128'(s_out_valid), 128'(0));
    chk("rst8_op_count", 128'(s_op_count), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_after", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic lit_op(input string nm, input lu_op_t o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eo,
                        input logic ez, input logic en);
    int lat;
    out_ready = 1'b1;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 128'(lat), 128'(S));
    chk({nm, "_out"}, 128'(out), 128'(eo));
    chk({nm, "_zero"}, 128'(zero), 128'(ez));
    chk({nm, "_negative"}, 128'(negative), 128'(en));
    @(posedge clk);
    #1;
  endtask

  task automatic lit8(input string nm, input lu_op_t o, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] eo,
                      input logic ez, input logic en);
    int lat;
    s_op = o; s_a = x; s_b = y; s_in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 128'(s_in_ready), 128'(1));
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (s_out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 128'(lat), 128'(1));
    chk({nm, "_out"}, 128'(s_out), 128'(eo));
    chk({nm, "_zero"}, 128'(s_zero), 128'(ez));
    chk({nm, "_negative"}, 128'(s_negative), 128'(en));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c0;
    int n_acc;

    // Reset state
    do_reset();

    // Directed single operations with hand-computed results
    lit_op("xor_1_0", OP_XOR, 64'h1, 64'h0, 64'h1, 1'b0, 1'b0);
    lit_op("xor_1_1", OP_XOR, 64'h1, 64'h1, 64'h0, 1'b1, 1'b0);
    lit_op("nor_0_0", OP_NOR, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    lit_op("andn", OP_ANDN, 64'hF0, 64'h30, 64'hC0, 1'b0, 1'b0);
    lit_op("and", OP_AND, 64'hFF00_FF00_1234_5678, 64'h0FF0_0FF0_FFFF_0000,
           64'h0F00_0F00_1234_0000, 1'b0, 1'b0);
    lit_op("nota", OP_NOTA, 64'h8000_0000_0000_0001, 64'h0,
           64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    // Every opcode back-to-back, checked by the model
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(lu_op_t'(i), 64'hDEAD_BEEF_0123_4567 ^ 64'(i), 64'hF0F0_0F0F_AAAA_5555);
    idle(4);

    // Streaming: 10 back-to-back XORs
    do_reset();
    out_ready = 1'b1;
    base = hs_cyc.size();
    c0 = cyc;
    for (int i = 0; i < 10; i++)
      send(OP_XOR, 64'(i) * 64'h0101_0101_0101_0101, 64'h00FF_00FF_00FF_00FF);
    idle(5);
    chk("stream_count", 128'(hs_cyc.size() - base), 128'(10));
    if (hs_cyc.size() - base >= 10) begin
      chk("stream_first_cycle", 128'(hs_cyc[base] - c0), 128'(2));
      chk("stream_span", 128'(hs_cyc[base+9] - hs_cyc[base]), 128'(9));
    end
    chk("stream_op_count", 128'(op_count), 128'(10));

    // Backpressure: consumer stalls for 5 cycles while input keeps coming
    base = hs_cyc.size();
    out_ready = 1'b0;
    n_acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op = OP_XNOR;
      a = 64'(n_acc) ^ 64'hA5A5_0000_0000_0000;
      b = 64'h0F;
      @(negedge clk);
      if (in_ready) n_acc++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepts", 128'(n_acc), 128'(S));
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    chk("bp_out_valid_held", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    while (n_acc < 6) begin
      send(OP_XNOR, 64'(n_acc) ^ 64'hA5A5_0000_0000_0000, 64'h0F);
      n_acc++;
    end
    idle(5);
    chk("bp_results", 128'(hs_cyc.size() - base), 128'(6));
    chk("bp_op_count", 128'(op_count), 128'(16));

    // Random valid/ready interplay with stalls and bubbles
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      op = lu_op_t'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(6);

    // Reset with two operations in flight
    out_ready = 1'b0;
    send(OP_OR, 64'h11, 64'h22);
    send(OP_OR, 64'h33, 64'h44);
    in_valid = 1'b0;
    chk("mid_full_before_reset", 128'(out_valid), 128'(1));
    do_reset();
    out_ready = 1'b1;
    base = hs_cyc.size();
    idle(6);
    chk("mid_no_stale", 128'(hs_cyc.size() - base), 128'(0));
    chk("mid_out_valid", 128'(out_valid), 128'(0));
    chk("mid_op_count", 128'(op_count), 128'(0));

    // Saturation: 65540 transfers
    out_ready = 1'b1;
    op = OP_OR; a = 64'h5; b = 64'h8; in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    idle(5);
    chk("sat_op_count", 128'(op_count), 128'(16'hFFFF));

    // Narrow single-stage build
    lit8("w8_xor_1_0", OP_XOR, 8'h1, 8'h0, 8'h1, 1'b0, 1'b0);
    lit8("w8_xor_1_1", OP_XOR, 8'h1, 8'h1, 8'h0, 1'b1, 1'b0);
    lit8("w8_nor_0_0", OP_NOR, 8'h0, 8'h0, 8'hFF, 1'b0, 1'b1);
    chk("w8_op_count", 128'(s_op_count), 128'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
